// File: rtl/spi_slave_engine.sv
// spi_slave_engine
//   Slave-side SPI engine. SCLK, MOSI and CS_n are oversampled on clk, MOSI is
//   deserialised into rx_data, and a word from a one-entry holding buffer is
//   serialised onto MISO. Reports transmit underrun and aborted frames.
//
// Ports
//   clk, rst             system clock, async active-high reset
//   sclk_in, mosi_in,    asynchronous SPI pins from the master
//   cs_n_in
//   miso_out, miso_oe    serial data out and its enable (high while selected)
//   tx_data, tx_valid,   holding-buffer write handshake
//   tx_ready
//   rx_data, rx_valid    last complete received word and its one-cycle strobe
//   tx_underrun          pulse: frame started with holding buffer empty
//   frame_abort          pulse: CS_n released mid-frame
//
// state | meaning
// IDLE  | CS_n high, outputs disabled, bit counter cleared
// LOAD  | one cycle after CS_n fall (CPHA=0 reload happens on entry)
// SHIFT | counting sample edges, shifting on shift edges
module spi_slave_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_in,
  input  logic                  mosi_in,
  input  logic                  cs_n_in,
  output logic                  miso_out,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam logic SCLK_IDLE = (CPOL != 0);
  localparam int   CNT_W     = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nxt;

  // [0],[1] synchroniser, [2] edge-detect history
  logic [2:0] sclk_sync, mosi_sync, cs_sync;
  logic       lead_p, trail_p, cs_fall_p, cs_rise_p;

  logic [DATA_WIDTH-1:0] hold_buf;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [CNT_W-1:0]      bit_cnt;

  logic                  sample_p, shift_p, active;
  logic                  load_entry, wrap_start, frame_start;
  logic                  do_shift, do_sample, hs;
  logic [DATA_WIDTH-1:0] rx_word;

  // Edge pulses are registered, so mosi_sync[2] lines up with them one cycle
  // later; this fixes pin-to-action latency at four clk cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= {3{SCLK_IDLE}};
      mosi_sync <= 3'b000;
      cs_sync   <= 3'b111;
      lead_p    <= 1'b0;
      trail_p   <= 1'b0;
      cs_fall_p <= 1'b0;
      cs_rise_p <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk_in};
      mosi_sync <= {mosi_sync[1:0], mosi_in};
      cs_sync   <= {cs_sync[1:0], cs_n_in};
      lead_p    <= (sclk_sync[1] != SCLK_IDLE) && (sclk_sync[2] == SCLK_IDLE);
      trail_p   <= (sclk_sync[1] == SCLK_IDLE) && (sclk_sync[2] != SCLK_IDLE);
      cs_fall_p <= cs_sync[2] && !cs_sync[1];
      cs_rise_p <= !cs_sync[2] && cs_sync[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall_p) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   state_nxt = SHIFT;
      default: state_nxt = IDLE;
    endcase
    if (cs_rise_p) state_nxt = IDLE;
  end

  always_comb begin
    sample_p   = (CPHA != 0) ? trail_p : lead_p;
    shift_p    = (CPHA != 0) ? lead_p  : trail_p;
    active     = (state == SHIFT) && !cs_rise_p;
    load_entry = (state == IDLE) && cs_fall_p;
    // A shift edge with the counter at zero opens a frame: in CPHA=0 it is the
    // trailing edge after the last sample, in CPHA=1 the first leading edge.
    wrap_start = active && shift_p && (bit_cnt == '0);
    // With CPHA=1 the frame opens on the first leading edge, so LOAD must not
    // consume the buffer a second time.
    frame_start = (CPHA == 0) ? (load_entry || wrap_start) : wrap_start;
    do_shift   = active && shift_p && (bit_cnt != '0);
    do_sample  = active && sample_p;
    hs         = tx_valid && tx_ready;
    rx_word    = {rx_shift, mosi_sync[2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_buf    <= '0;
      buf_full    <= 1'b0;
      shreg       <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      // A handshake coinciding with a reload refills the buffer for the next
      // frame; the reload itself still sees the old contents.
      if (hs) hold_buf <= tx_data;
      if (hs)               buf_full <= 1'b1;
      else if (frame_start) buf_full <= 1'b0;

      if (frame_start) begin
        shreg       <= buf_full ? hold_buf : '1;
        tx_underrun <= !buf_full;
      end else if (do_shift) begin
        shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
      end

      if (cs_rise_p) begin
        bit_cnt     <= '0;
        frame_abort <= (state != IDLE) && (bit_cnt != '0);
      end else if (do_sample) begin
        rx_shift <= rx_word[DATA_WIDTH-2:0];
        if (bit_cnt == LAST_BIT) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign tx_ready = !buf_full;
  assign miso_oe  = (state != IDLE);
  assign miso_out = miso_oe && shreg[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_engine.sv
// Testbench for spi_slave_engine: four instances, one per SPI mode
// (index = CPOL*2 + CPHA), each with its own SCLK, CS_n and tx_valid.
module tb_spi_slave_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sclk     [4];
  logic       cs_n     [4];
  logic       tx_valid [4];
  logic       miso     [4];
  logic       oe       [4];
  logic       rdy      [4];
  logic       rxv      [4];
  logic       und      [4];
  logic       abt      [4];
  logic [7:0] rxd      [4];

  int rx_cnt  [4] = '{default: 0};
  int und_cnt [4] = '{default: 0};
  int abt_cnt [4] = '{default: 0};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_engine #(
      .DATA_WIDTH(8),
      .CPOL(g / 2),
      .CPHA(g % 2)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .sclk_in(sclk[g]),
      .mosi_in(mosi),
      .cs_n_in(cs_n[g]),
      .miso_out(miso[g]),
      .miso_oe(oe[g]),
      .tx_data(tx_data),
      .tx_valid(tx_valid[g]),
      .tx_ready(rdy[g]),
      .rx_data(rxd[g]),
      .rx_valid(rxv[g]),
      .tx_underrun(und[g]),
      .frame_abort(abt[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rxv[i]) rx_cnt[i]  <= rx_cnt[i] + 1;
      if (und[i]) und_cnt[i] <= und_cnt[i] + 1;
      if (abt[i]) abt_cnt[i] <= abt_cnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic half_wait(input int m, input bit push, input logic [7:0] w);
    for (int c = 0; c < 8; c++) begin
      if (push && c == 0) begin
        tx_data     = w;
        tx_valid[m] = 1'b1;
      end else begin
        tx_valid[m] = 1'b0;
      end
      @(negedge clk);
    end
    tx_valid[m] = 1'b0;
  endtask

  task automatic push_tx(input int m, input logic [7:0] w);
    int t;
    t = 0;
    while (!rdy[m] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("push_ready", rdy[m], 1);
    tx_data     = w;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic cs_high(input int m);
    repeat (8) @(negedge clk);
    cs_n[m] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Master side of one frame (or the first nbits of it), MSB first.
  task automatic xfer(input int m, input logic [7:0] mo, input int nbits,
                      input bit push, input logic [7:0] pw, output logic [7:0] mi);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2) == 1;
    mi   = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[7-i];
        half_wait(m, push && i == 3, pw);
        mi[7-i] = miso[m];
        sclk[m] = ~cpol;
        half_wait(m, 1'b0, pw);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi    = mo[7-i];
        half_wait(m, push && i == 3, pw);
        mi[7-i] = miso[m];
        sclk[m] = cpol;
        half_wait(m, 1'b0, pw);
      end
    end
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int r0, u0, a0;
    for (int i = 0; i < 4; i++) begin
      sclk[i]     = (i >= 2);
      cs_n[i]     = 1'b1;
      tx_valid[i] = 1'b0;
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx_ready", rdy[i], 1);
      chk("rst_miso_oe", oe[i], 0);
    end
    chk("rst_miso_out", miso[0], 0);
    chk("rst_rx_data", rxd[0], 0);
    chk("rst_rx_valid", rxv[0], 0);
    chk("rst_underrun", und[0], 0);
    chk("rst_abort", abt[0], 0);

    // mode 0: slave 0xA5, master 0x3C
    push_tx(0, 8'hA5);
    chk("m0_ready_low", rdy[0], 0);
    r0 = rx_cnt[0]; u0 = und_cnt[0]; a0 = abt_cnt[0];
    cs_low(0);
    chk("m0_oe", oe[0], 1);
    chk("m0_ready_after_load", rdy[0], 1);
    chk("m0_no_underrun", und_cnt[0] - u0, 0);
    xfer(0, 8'h3C, 8, 1'b0, 8'h00, mi);
    chk("m0_miso", mi, 8'hA5);
    cs_high(0);
    chk("m0_rx_data", rxd[0], 8'h3C);
    chk("m0_rx_pulses", rx_cnt[0] - r0, 1);
    chk("m0_no_abort", abt_cnt[0] - a0, 0);
    chk("m0_oe_off", oe[0], 0);
    chk("m0_miso_off", miso[0], 0);

    // modes 1..3: slave 0x7E, master 0x81
    for (int m = 1; m < 4; m++) begin
      push_tx(m, 8'h7E);
      r0 = rx_cnt[m];
      cs_low(m);
      xfer(m, 8'h81, 8, 1'b0, 8'h00, mi);
      cs_high(m);
      chk($sformatf("m%0d_miso", m), mi, 8'h7E);
      chk($sformatf("m%0d_rx_data", m), rxd[m], 8'h81);
      chk($sformatf("m%0d_rx_pulses", m), rx_cnt[m] - r0, 1);
    end

    // underrun: empty at CS_n fall, word supplied mid-frame for the next start
    u0 = und_cnt[0];
    cs_low(0);
    chk("ur_at_load", und_cnt[0] - u0, 1);
    xfer(0, 8'h96, 8, 1'b1, 8'h33, mi);
    chk("ur_miso", mi, 8'hFF);
    cs_high(0);
    chk("ur_once", und_cnt[0] - u0, 1);
    chk("ur_rx_data", rxd[0], 8'h96);
    chk("ur_ready", rdy[0], 1);

    // back-to-back frames under one CS_n
    push_tx(0, 8'h11);
    r0 = rx_cnt[0];
    cs_low(0);
    xfer(0, 8'hC3, 8, 1'b1, 8'h22, mi);
    chk("b2b_rx1", rxd[0], 8'hC3);
    xfer(0, 8'h5A, 8, 1'b0, 8'h00, mi2);
    cs_high(0);
    chk("b2b_miso1", mi, 8'h11);
    chk("b2b_miso2", mi2, 8'h22);
    chk("b2b_rx2", rxd[0], 8'h5A);
    chk("b2b_rx_pulses", rx_cnt[0] - r0, 2);

    // abort after 5 bits; buffer written mid-frame must survive
    push_tx(0, 8'h55);
    r0 = rx_cnt[0]; a0 = abt_cnt[0];
    cs_low(0);
    xfer(0, 8'hB7, 5, 1'b1, 8'hE1, mi);
    cs_high(0);
    chk("ab_abort", abt_cnt[0] - a0, 1);
    chk("ab_no_rx", rx_cnt[0] - r0, 0);
    chk("ab_rx_hold", rxd[0], 8'h5A);
    chk("ab_buf_kept", rdy[0], 0);
    r0 = rx_cnt[0]; a0 = abt_cnt[0];
    cs_low(0);
    xfer(0, 8'h2D, 8, 1'b0, 8'h00, mi);
    cs_high(0);
    chk("ab_next_miso", mi, 8'hE1);
    chk("ab_next_rx", rxd[0], 8'h2D);
    chk("ab_next_pulses", rx_cnt[0] - r0, 1);
    chk("ab_next_no_abort", abt_cnt[0] - a0, 0);

    // reset mid-frame
    push_tx(0, 8'h0F);
    r0 = rx_cnt[0]; a0 = abt_cnt[0];
    cs_low(0);
    xfer(0, 8'hFF, 3, 1'b0, 8'h00, mi);
    rst = 1'b1;
    #1;
    chk("mr_oe", oe[0], 0);
    chk("mr_miso", miso[0], 0);
    chk("mr_ready", rdy[0], 1);
    chk("mr_rx_data", rxd[0], 0);
    cs_n[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mr_no_rx", rx_cnt[0] - r0, 0);
    chk("mr_no_abort", abt_cnt[0] - a0, 0);
    push_tx(0, 8'h42);
    cs_low(0);
    xfer(0, 8'hA7, 8, 1'b0, 8'h00, mi);
    cs_high(0);
    chk("mr_next_miso", mi, 8'h42);
    chk("mr_next_rx", rxd[0], 8'hA7);
    chk("mr_next_pulses", rx_cnt[0] - r0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_engine.md
# spi_slave_engine

Slave-side SPI engine: the responder at the far end of the master's per-slave MISO select. It oversamples the master's SCLK, MOSI and CS_n on its own system clock, deserialises MOSI into parallel words, and serialises a user-supplied word onto MISO. It has a one-entry transmit holding buffer with a valid/ready handshake and reports underrun and aborted frames.

## Interface
- DATA_WIDTH, 8: bits per frame, MSB first; legal range 4..32.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.

- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sclk_in  input  1  SCLK from the master; asynchronous to clk.
- mosi_in  input  1  MOSI from the master; asynchronous.
- cs_n_in  input  1  slave chip select, active low; asynchronous.
- miso_out  output  1  serial data to the master's MISO select.
- miso_oe  output  1  high while this slave is selected (synchronised CS_n low).
- tx_data  input  DATA_WIDTH  word for a following frame.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding buffer is empty.
- rx_data  output  DATA_WIDTH  last complete received word; holds until the next completed frame.
- rx_valid  output  1  one-cycle pulse marking a new rx_data.
- tx_underrun  output  1  one-cycle pulse: a frame started with the holding buffer empty.
- frame_abort  output  1  one-cycle pulse: CS_n deasserted mid-frame.

## Operation
- sclk_in, mosi_in and cs_n_in each pass through a 2-flop synchroniser, followed by a third register for edge detection.
- Leading edge is the SCLK transition away from CPOL. Trailing edge is the transition back to CPOL.
- FSM states:
  - IDLE: synchronised CS_n is high. miso_oe=0, bit counter=0.
  - LOAD: a single cycle on the CS_n falling edge. Moves the holding buffer to the shift register. Next state is SHIFT.
  - SHIFT: counts sample edges.
  - CS_n rising in any state returns the FSM to IDLE.
- Holding buffer:
  - A handshake occurs when tx_valid && tx_ready. The holding buffer captures tx_data on that cycle and tx_ready falls on the next cycle.
  - Each frame start moves the buffer into the shift register and sets tx_ready=1.
  - If the buffer is empty at frame start, the shift register loads all ones and tx_underrun pulses.
- CPHA=0:
  - Frame start is LOAD, so the MSB is on miso_out before the first leading edge.
  - Each trailing edge shifts left.
  - The trailing edge after the last sample of a frame does not shift. It is the start of the next frame: reload from the holding buffer.
- CPHA=1:
  - Frame start is the first leading edge of each frame; reload there and drive the MSB.
  - Later leading edges shift left.
- Sample edge: mosi is shifted into the receive register LSB and the bit counter increments.
  - When the counter reaches DATA_WIDTH, the received word is copied to rx_data, rx_valid pulses, and the counter wraps to 0.
  - Back-to-back frames within one CS_n assertion are supported with no gap.
- CS_n rising with the bit counter ≠ 0:
  - Partial data is discarded; no rx_valid is generated.
  - frame_abort pulses.
  - The counter clears.
  - The holding buffer keeps its contents if it was not yet consumed.
- CS_n rising with the counter = 0: no pulse.
- miso_out is the shift register MSB while miso_oe=1, otherwise 0.
- SCLK edges seen while CS_n is high are ignored.

## Timing
- Reset values: miso_out=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0, FSM=IDLE, holding buffer empty.
- Input to internal edge pulse: 3 clk cycles.
- rx_valid is high on the 4th clk rising edge after the final sample edge at the pin.
- miso_oe rises 4 clk cycles after cs_n_in falls. The MSB is valid on the same cycle (CPHA=0).
- Shift-edge to miso_out change: 4 clk cycles.
- SCLK high and low phases must each be ≥ 4 clk periods.
- CS_n falling to the first SCLK edge must be ≥ 6 clk periods.
- A tx handshake on the same cycle as a frame-start reload:
  - The reload consumes the old buffer contents; if the buffer was empty, it takes the all-ones underrun value.
  - The new word is captured into the buffer for the next frame.
  - tx_ready stays 0.
- Reset asserted mid-frame forces all reset values immediately. No rx_valid or frame_abort is generated.

## Test plan
- Mode 0, DATA_WIDTH=8. Preload tx_data=0xA5, then the master sends 0x3C -> MISO carries 0xA5 MSB first, rx_data=0x3C with a single rx_valid pulse, and tx_ready=1 after LOAD.
- Modes 1, 2 and 3, with master 0x81 and slave 0x7E -> both sides are correct in every mode.
- Buffer empty at CS_n fall -> MISO sends 0xFF and tx_underrun pulses once.
- Two back-to-back frames under one CS_n, with buffer 0x11 and then 0x22 supplied mid-frame 1 -> MISO sends 0x11, 0x22. rx_valid pulses twice with 0xC3 and 0x5A.
- CS_n raised after 5 bits -> frame_abort pulses, there is no rx_valid, and the next full frame receives correctly.
- rst pulsed mid-frame -> all outputs return to their reset values asynchronously, and the next frame is received cleanly.
